// File: rtl/irq_ctrl.sv
// Interrupt controller for the 18-bit accumulator processor.
// One request to the ControlBlock, fixed input-over-output priority, no nesting.
module irq_ctrl #(
    parameter int                ADDR_W  = 13,
    parameter logic [ADDR_W-1:0] VEC_IN  = 13'h0010,
    parameter logic [ADDR_W-1:0] VEC_OUT = 13'h0018,
    parameter int                OVF_W   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flg_i,
    input  logic              flg_o,
    input  logic              cfg_we,
    input  logic [2:0]        cfg_data,
    input  logic              irq_ack,
    input  logic              irq_ret,
    output logic              irq_req,
    output logic [ADDR_W-1:0] irq_vec,
    output logic [1:0]        irq_src,
    output logic              in_service,
    output logic [2:0]        ie_state,
    output logic [1:0]        pend,
    output logic [OVF_W-1:0]  ovf_i,
    output logic [OVF_W-1:0]  ovf_o
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_SVC} state_t;

    state_t            r_state, w_state_nx;
    logic              r_fi_d, r_fo_d;
    logic [1:0]        r_pend, w_pend_nx;
    logic [OVF_W-1:0]  r_ovf_i, r_ovf_o, w_ovf_i_nx, w_ovf_o_nx;
    logic [2:0]        r_ie, w_ie_nx;
    logic              r_req, w_req_nx;
    logic              r_svc, w_svc_nx;
    logic [1:0]        r_src, w_src_nx;
    logic [ADDR_W-1:0] r_vec, w_vec_nx;

    logic              w_edge_i, w_edge_o;
    logic              w_qi, w_qo, w_any;
    logic              w_ack, w_ret, w_clr_i, w_clr_o;
    logic [1:0]        w_win_src;
    logic [ADDR_W-1:0] w_win_vec;

    assign w_edge_i  = flg_i & ~r_fi_d;
    assign w_edge_o  = flg_o & ~r_fo_d;
    assign w_qi      = r_pend[0] & r_ie[1];
    assign w_qo      = r_pend[1] & r_ie[2];
    assign w_any     = r_ie[0] & (w_qi | w_qo);
    assign w_ack     = (r_state == S_REQ) & w_any & irq_ack;
    assign w_ret     = (r_state == S_SVC) & irq_ret;
    assign w_clr_i   = w_ack & w_qi;
    assign w_clr_o   = w_ack & ~w_qi;
    assign w_win_src = w_qi ? 2'b01 : 2'b10;
    assign w_win_vec = w_qi ? VEC_IN : VEC_OUT;

    // A new edge on an already-pending source is an overrun, unless
    // that same pend bit is being consumed by the ack this cycle.
    always_comb begin
        w_pend_nx  = r_pend;
        w_ovf_i_nx = r_ovf_i;
        w_ovf_o_nx = r_ovf_o;
        if (w_edge_i) begin
            w_pend_nx[0] = 1'b1;
            if (r_pend[0] & ~w_clr_i & ~(&r_ovf_i))
                w_ovf_i_nx = r_ovf_i + 1'b1;
        end else if (w_clr_i) begin
            w_pend_nx[0] = 1'b0;
        end
        if (w_edge_o) begin
            w_pend_nx[1] = 1'b1;
            if (r_pend[1] & ~w_clr_o & ~(&r_ovf_o))
                w_ovf_o_nx = r_ovf_o + 1'b1;
        end else if (w_clr_o) begin
            w_pend_nx[1] = 1'b0;
        end
    end

    always_comb begin
        w_ie_nx = cfg_we ? cfg_data : r_ie;
        if (w_ack)
            w_ie_nx[0] = 1'b0;
        if (w_ret)
            w_ie_nx[0] = 1'b1;
    end

    always_comb begin
        w_state_nx = r_state;
        w_req_nx   = r_req;
        w_svc_nx   = r_svc;
        w_src_nx   = r_src;
        w_vec_nx   = r_vec;
        unique case (r_state)
            S_IDLE: begin
                if (w_any) begin
                    w_state_nx = S_REQ;
                    w_req_nx   = 1'b1;
                    w_src_nx   = w_win_src;
                    w_vec_nx   = w_win_vec;
                end
            end
            S_REQ: begin
                if (!w_any) begin
                    w_state_nx = S_IDLE;
                    w_req_nx   = 1'b0;
                    w_src_nx   = 2'b00;
                end else begin
                    w_src_nx = w_win_src;
                    w_vec_nx = w_win_vec;
                    if (irq_ack) begin
                        w_state_nx = S_SVC;
                        w_req_nx   = 1'b0;
                        w_svc_nx   = 1'b1;
                    end
                end
            end
            S_SVC: begin
                if (irq_ret) begin
                    w_state_nx = S_IDLE;
                    w_svc_nx   = 1'b0;
                    w_src_nx   = 2'b00;
                end
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_fi_d  <= 1'b0;
            r_fo_d  <= 1'b0;
            r_pend  <= '0;
            r_ovf_i <= '0;
            r_ovf_o <= '0;
            r_ie    <= '0;
            r_req   <= 1'b0;
            r_svc   <= 1'b0;
            r_src   <= '0;
            r_vec   <= '0;
        end else begin
            r_state <= w_state_nx;
            r_fi_d  <= flg_i;
            r_fo_d  <= flg_o;
            r_pend  <= w_pend_nx;
            r_ovf_i <= w_ovf_i_nx;
            r_ovf_o <= w_ovf_o_nx;
            r_ie    <= w_ie_nx;
            r_req   <= w_req_nx;
            r_svc   <= w_svc_nx;
            r_src   <= w_src_nx;
            r_vec   <= w_vec_nx;
        end
    end

    assign irq_req    = r_req;
    assign irq_vec    = r_vec;
    assign irq_src    = r_src;
    assign in_service = r_svc;
    assign ie_state   = r_ie;
    assign pend       = r_pend;
    assign ovf_i      = r_ovf_i;
    assign ovf_o      = r_ovf_o;

endmodule

// File: tb/tb_irq_ctrl.sv
// Bench for irq_ctrl: directed plan steps then random traffic,
// every cycle compared against a behavioural model.
module tb_irq_ctrl;

    localparam int M_IDLE = 0;
    localparam int M_REQ  = 1;
    localparam int M_SVC  = 2;
    localparam logic [12:0] VIN  = 13'h0010;
    localparam logic [12:0] VOUT = 13'h0018;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flg_i = 1'b0, flg_o = 1'b0;
    logic        cfg_we = 1'b0;
    logic [2:0]  cfg_data = 3'b000;
    logic        irq_ack = 1'b0, irq_ret = 1'b0;
    logic        irq_req;
    logic [12:0] irq_vec;
    logic [1:0]  irq_src;
    logic        in_service;
    logic [2:0]  ie_state;
    logic [1:0]  pend;
    logic [3:0]  ovf_i, ovf_o;

    int ncmp = 0;
    int nerr = 0;

    int          m_st = M_IDLE;
    bit          m_pi, m_po, m_glob, m_eni, m_eno, m_req, m_svc;
    bit [1:0]    m_pend, m_src;
    bit [12:0]   m_vec;
    int          m_ovi, m_ovo;

    irq_ctrl dut (
        .clk(clk), .rst(rst), .flg_i(flg_i), .flg_o(flg_o),
        .cfg_we(cfg_we), .cfg_data(cfg_data),
        .irq_ack(irq_ack), .irq_ret(irq_ret),
        .irq_req(irq_req), .irq_vec(irq_vec), .irq_src(irq_src),
        .in_service(in_service), .ie_state(ie_state), .pend(pend),
        .ovf_i(ovf_i), .ovf_o(ovf_o)
    );

    always #5 clk = ~clk;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        bit ei, eo, qi, qo, any, ack, ret;
        if (!rst) begin
            m_st = M_IDLE; m_pi = 0; m_po = 0; m_pend = 0;
            m_ovi = 0; m_ovo = 0; m_glob = 0; m_eni = 0; m_eno = 0;
            m_req = 0; m_svc = 0; m_src = 0; m_vec = 0;
            return;
        end
        ei  = flg_i && !m_pi;
        eo  = flg_o && !m_po;
        qi  = m_pend[0] && m_eni;
        qo  = m_pend[1] && m_eno;
        any = m_glob && (qi || qo);
        ack = (m_st == M_REQ) && any && irq_ack;
        ret = (m_st == M_SVC) && irq_ret;
        if (ei) begin
            if (m_pend[0] && !(ack && qi)) m_ovi = (m_ovi < 15) ? m_ovi + 1 : 15;
            m_pend[0] = 1;
        end else if (ack && qi) m_pend[0] = 0;
        if (eo) begin
            if (m_pend[1] && !(ack && !qi)) m_ovo = (m_ovo < 15) ? m_ovo + 1 : 15;
            m_pend[1] = 1;
        end else if (ack && !qi) m_pend[1] = 0;
        if (cfg_we) {m_eno, m_eni, m_glob} = cfg_data;
        if (ack) m_glob = 0;
        if (ret) m_glob = 1;
        if (m_st == M_IDLE && any) begin
            m_st = M_REQ; m_req = 1;
            m_src = qi ? 2'b01 : 2'b10; m_vec = qi ? VIN : VOUT;
        end else if (m_st == M_REQ && !any) begin
            m_st = M_IDLE; m_req = 0; m_src = 0;
        end else if (m_st == M_REQ) begin
            m_src = qi ? 2'b01 : 2'b10; m_vec = qi ? VIN : VOUT;
            if (irq_ack) begin m_st = M_SVC; m_req = 0; m_svc = 1; end
        end else if (ret) begin
            m_st = M_IDLE; m_svc = 0; m_src = 0;
        end
        m_pi = flg_i; m_po = flg_o;
    endtask

    task automatic cyc();
        model_step();
        @(posedge clk);
        #1;
        chk("irq_req", 32'(irq_req), 32'(m_req));
        chk("irq_vec", 32'(irq_vec), 32'(m_vec));
        chk("irq_src", 32'(irq_src), 32'(m_src));
        chk("in_service", 32'(in_service), 32'(m_svc));
        chk("ie_state", 32'(ie_state), 32'({m_eno, m_eni, m_glob}));
        chk("pend", 32'(pend), 32'(m_pend));
        chk("ovf_i", 32'(ovf_i), 32'(m_ovi));
        chk("ovf_o", 32'(ovf_o), 32'(m_ovo));
    endtask

    task automatic cfg(logic [2:0] d);
        cfg_we = 1; cfg_data = d; cyc(); cfg_we = 0;
    endtask

    initial begin
        // reset then enable
        rst = 0; cyc(); cyc();
        chk("rst_req", 32'(irq_req), 0);
        chk("rst_ie", 32'(ie_state), 0);
        rst = 1;
        cfg(3'b011);
        flg_i = 1; cyc();
        chk("plan_pend", 32'(pend), 32'h1);
        cyc();
        chk("plan_req", 32'(irq_req), 1);
        chk("plan_vec", 32'(irq_vec), 32'h10);
        chk("plan_src", 32'(irq_src), 32'h1);
        // ack / return
        irq_ack = 1; cyc(); irq_ack = 0;
        chk("ack_svc", 32'(in_service), 1);
        chk("ack_ie", 32'(ie_state), 32'h2);
        chk("ack_pend", 32'(pend), 0);
        irq_ret = 1; cyc(); irq_ret = 0;
        chk("ret_svc", 32'(in_service), 0);
        chk("ret_ie", 32'(ie_state), 32'h3);
        // priority
        flg_i = 0; cfg(3'b111);
        flg_o = 1; cyc(); cyc();
        chk("pri_vec_out", 32'(irq_vec), 32'h18);
        flg_i = 1; cyc(); cyc();
        chk("pri_vec_in", 32'(irq_vec), 32'h10);
        irq_ack = 1; cyc(); irq_ack = 0;
        irq_ret = 1; cyc(); irq_ret = 0;
        cyc();
        chk("pri_second", 32'(irq_vec), 32'h18);
        irq_ack = 1; cyc(); irq_ack = 0;
        irq_ret = 1; cyc(); irq_ret = 0;
        // withdrawal
        flg_i = 0; cyc(); flg_i = 1; cyc(); cyc();
        chk("wd_req_before", 32'(irq_req), 1);
        cfg(3'b110); cyc();
        chk("wd_req", 32'(irq_req), 0);
        chk("wd_pend", 32'(pend[0]), 1);
        // overrun saturation
        cfg(3'b000);
        for (int k = 0; k < 20; k++) begin
            flg_i = 0; cyc(); flg_i = 1; cyc();
        end
        chk("ovf_sat", 32'(ovf_i), 32'hF);
        // reset mid-service
        cfg(3'b011); cyc();
        irq_ack = 1; cyc(); irq_ack = 0;
        chk("svc_enter", 32'(in_service), 1);
        rst = 0; cyc(); rst = 1;
        chk("mid_rst_svc", 32'(in_service), 0);
        chk("mid_rst_vec", 32'(irq_vec), 0);
        chk("mid_rst_ovf", 32'(ovf_i), 0);
        irq_ret = 1; cyc(); irq_ret = 0;
        chk("ret_ignored", 32'(ie_state), 0);
        // random traffic
        for (int k = 0; k < 600; k++) begin
            rst      = ($urandom_range(0, 149) != 0);
            if ($urandom_range(0, 3) == 0) flg_i = ~flg_i;
            if ($urandom_range(0, 4) == 0) flg_o = ~flg_o;
            cfg_we   = ($urandom_range(0, 7) == 0);
            cfg_data = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 1) == 0) cfg_data[0] = 1'b1;
            irq_ack  = ($urandom_range(0, 2) == 0);
            irq_ret  = ($urandom_range(0, 3) == 0);
            cyc();
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule

// File: doc/irq_ctrl.md
Name: irq_ctrl

Overview:
Interrupt controller for the 18-bit accumulator processor. It latches the input-ready and output-ready flags from the I/O register block and owns the global, input and output interrupt enables. It raises one request to the ControlBlock and, on acknowledge at an instruction boundary, supplies the handler vector to load into the PC. It masks further requests until the handler's return pulse.

Parameters:
ADDR_W, 13, width of the PC/MAR address and of the vector output
VEC_IN, 13'h0010, handler address for the input-ready interrupt
VEC_OUT, 13'h0018, handler address for the output-ready interrupt
OVF_W, 4, width of each saturating overrun counter

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous reset, active-low: sampled on rising clk, asserted when 0
flg_i  input  1  input-ready level flag from the I/O register block
flg_o  input  1  output-ready level flag from the I/O register block
cfg_we  input  1  one-cycle write strobe for the enable register
cfg_data  input  3  bit0 glob_ie, bit1 en_i, bit2 en_o
irq_ack  input  1  ControlBlock accepts the request (instruction boundary)
irq_ret  input  1  one-cycle pulse on return-from-interrupt
irq_req  output  1  interrupt request to ControlBlock, registered
irq_vec  output  ADDR_W  handler address, valid while irq_req=1 and held in SERVICE
irq_src  output  2  01 = input, 10 = output, 00 = none
in_service  output  1  handler active
ie_state  output  3  current {en_o, en_i, glob_ie}
pend  output  2  pending latches {out, in}
ovf_i  output  OVF_W  input-flag overrun count
ovf_o  output  OVF_W  output-flag overrun count

Behaviour:
- Reset (rst=0 at posedge): state=IDLE. All outputs are 0, including the enables, pending latches, overrun counters and irq_vec. Reset overrides every other input, including a reset mid-SERVICE.
- Edge detect: each flag is registered once. A rising edge (flag=1, previous=0) sets the matching pend bit.
  - If that pend bit is already 1, the edge increments that source's ovf counter. The counter saturates at all-ones.
- Enables: cfg_we loads {en_o, en_i, glob_ie} from cfg_data on the next edge. Enables do not gate the latching of pend.
- Qualified source:
  - qi = pend[0] & en_i; qo = pend[1] & en_o.
  - Input has fixed priority over output.
- State machine, with states IDLE, REQ and SERVICE:
  - IDLE: if glob_ie & (qi|qo), go to REQ. On that edge set irq_req=1, and set irq_src/irq_vec from the winner (VEC_IN/01 or VEC_OUT/10). Request latency is 1 cycle after the qualifying condition.
  - REQ: irq_req stays 1. The winner is re-evaluated every cycle, so a higher-priority input arriving updates irq_vec/irq_src before the ack.
    - If glob_ie=0 or no qualified source remains, go to IDLE: irq_req=0, irq_src=00 (request withdrawn).
    - On irq_ack=1, go to SERVICE. On that edge: irq_req=0, in_service=1, clear the winning pend bit, clear glob_ie. irq_vec/irq_src hold the accepted value.
  - SERVICE: holds until irq_ret=1. Then go to IDLE: in_service=0, glob_ie=1, irq_src=00, irq_vec holds its last value.
- Ignored inputs: irq_ack outside REQ and irq_ret outside SERVICE have no effect.
- Simultaneous events:
  - Edge on the same source in the ack cycle: the set wins, so pend stays 1 and ovf does not increment.
  - cfg_we in the ack cycle: en bits take cfg_data, but glob_ie is forced 0.
  - cfg_we in the irq_ret cycle: glob_ie is forced 1 and the en bits take cfg_data.
  - irq_ack and a withdrawal condition in the same cycle: the ack wins only if a qualified source exists in that cycle with glob_ie=1; otherwise the block withdraws.
- No nesting: no request is raised in SERVICE even if software sets glob_ie. The block re-evaluates in IDLE on the cycle after return.

Test Plan:
- Reset then enable: hold rst=0 for 2 cycles, then release. Write cfg_data=3'b011, then raise flg_i. Required: pend=01 on the next edge, irq_req=1 one cycle later, irq_vec=13'h0010, irq_src=01.
- Ack/return: in REQ pulse irq_ack. Required: next cycle irq_req=0, in_service=1, pend[0]=0, ie_state=3'b010. Then pulse irq_ret. Required: in_service=0, ie_state=3'b011.
- Priority: cfg_data=3'b111; raise flg_o, then raise flg_i one cycle later while in REQ. Required: irq_vec changes 0x0018 to 0x0010 before the ack. After ack+ret, a second request appears with irq_vec=0x0018.
- Withdrawal: in REQ, write cfg_data=3'b110. Required: next cycle state IDLE, irq_req=0, and pend is kept.
- Overrun saturation: enables off; toggle flg_i 0→1 twenty times. Required: pend[0]=1 and ovf_i=4'hF.
- Reset mid-SERVICE: enter SERVICE, then drive rst=0 for 1 cycle. Required: all outputs 0, and irq_ret afterwards has no effect.
